// File: rtl/gate_check_pkg.sv
// Shared types and the reference gate function for the gate truth-table checker.
// The expected-value function only looks at the low n bits of the vector.
package gate_check_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [2:0] OP_LAST_LEGAL = 3'd5;

  function automatic logic gate_expected(op_e op, logic [7:0] v, int n);
    logic r_and;
    logic r_or;
    logic r_xor;
    logic res;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        r_and = r_and & v[i];
        r_or  = r_or  | v[i];
        r_xor = r_xor ^ v[i];
      end else begin
        r_and = r_and;
      end
    end
    case (op)
      OP_AND:  res = r_and;
      OP_OR:   res = r_or;
      OP_XOR:  res = r_xor;
      OP_NAND: res = ~r_and;
      OP_NOR:  res = ~r_or;
      OP_XNOR: res = ~r_xor;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference model: expected gate output for a given op and stimulus.
module gate_ref_model
  import gate_check_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      i_op,
  input  logic [N_IN-1:0] i_stim,
  output logic            o_expected
);

  logic [7:0] w_vec;

  assign w_vec      = 8'(i_stim);
  assign o_expected = gate_expected(op_e'(i_op), w_vec, N_IN);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Exhaustive sweep tester for an N_IN-input single-output gate: drives every vector,
// compares the DUT output with the reference model and accumulates the result.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  output logic [N_IN-1:0] stim,
  input  logic            dut_s,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            bad_op,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail
);

  localparam int unsigned      NVEC     = 32'd1 << N_IN;
  localparam logic [N_IN:0]    MAX_ERR  = NVEC[N_IN:0];
  localparam logic [N_IN-1:0]  ALL_ONES = {N_IN{1'b1}};
  localparam logic [3:0]       CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e          r_state,  w_state_nxt;
  logic [2:0]      r_op,     w_op_nxt;
  logic [3:0]      r_cnt,    w_cnt_nxt;
  logic [N_IN-1:0] r_stim,   w_stim_nxt;
  logic            r_busy,   w_busy_nxt;
  logic            r_done,   w_done_nxt;
  logic            r_bad_op, w_bad_op_nxt;
  logic [N_IN:0]   r_err,    w_err_nxt;
  logic [N_IN-1:0] r_ff,     w_ff_nxt;
  logic            w_expected;
  logic            w_mismatch;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .i_op       (r_op),
    .i_stim     (r_stim),
    .o_expected (w_expected)
  );

  assign w_mismatch = (dut_s != w_expected);

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= 3'd0;
      r_cnt    <= 4'd0;
      r_stim   <= {N_IN{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bad_op <= 1'b0;
      r_err    <= {(N_IN+1){1'b0}};
      r_ff     <= {N_IN{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stim   <= w_stim_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_bad_op <= w_bad_op_nxt;
      r_err    <= w_err_nxt;
      r_ff     <= w_ff_nxt;
    end
  end

  // Next-state and next-result logic for the sweep FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_cnt_nxt    = r_cnt;
    w_stim_nxt   = r_stim;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_bad_op_nxt = r_bad_op;
    w_err_nxt    = r_err;
    w_ff_nxt     = r_ff;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_op_nxt   = op;
          w_err_nxt  = {(N_IN+1){1'b0}};
          w_ff_nxt   = {N_IN{1'b0}};
          w_stim_nxt = {N_IN{1'b0}};
          w_cnt_nxt  = CNT_LOAD;
          if (op <= OP_LAST_LEGAL) begin
            w_state_nxt  = ST_DRIVE;
            w_busy_nxt   = 1'b1;
            w_done_nxt   = 1'b0;
            w_bad_op_nxt = 1'b0;
          end else begin
            // Illegal op never drives a vector; report immediately.
            w_state_nxt  = ST_DONE;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
            w_bad_op_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (w_mismatch) begin
          if (r_err == {(N_IN+1){1'b0}}) begin
            w_ff_nxt = r_stim;
          end else begin
            w_ff_nxt = r_ff;
          end
          if (r_err != MAX_ERR) begin
            w_err_nxt = r_err + {{N_IN{1'b0}}, 1'b1};
          end else begin
            w_err_nxt = r_err;
          end
        end else begin
          w_err_nxt = r_err;
        end
        if (r_stim == ALL_ONES) begin
          w_state_nxt = ST_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_stim_nxt  = r_stim + {{(N_IN-1){1'b0}}, 1'b1};
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_DRIVE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign stim       = r_stim;
  assign busy       = r_busy;
  assign done       = r_done;
  assign bad_op     = r_bad_op;
  assign err_count  = r_err;
  assign first_fail = r_ff;
  assign pass       = r_done && (r_err == {(N_IN+1){1'b0}}) && !r_bad_op;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Scoreboard bench: two checker instances (N_IN=2/SETTLE=1 and N_IN=3/SETTLE=3),
// expected sweep results queued at issue time and checked when done rises.
module tb_gate_truth_table_checker;

  typedef struct {
    int err;
    int ff;
    int pass;
    int bad;
    int stim;
    int len;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [2:0] op_a, op_b;
  logic [1:0] stim_a;
  logic [2:0] stim_b;
  logic       dut_a, dut_b;
  logic       busy_a, done_a, pass_a, bad_a;
  logic       busy_b, done_b, pass_b, bad_b;
  logic [2:0] err_a;
  logic [3:0] err_b;
  logic [1:0] ff_a;
  logic [2:0] ff_b;

  int   mode_a;
  int   total;
  int   bad;
  int   len_a, len_b;
  logic prev_done_a, prev_done_b;
  exp_t qa[$];
  exp_t qb[$];

  gate_truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .op(op_a), .stim(stim_a), .dut_s(dut_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .bad_op(bad_a),
    .err_count(err_a), .first_fail(ff_a)
  );

  gate_truth_table_checker #(.N_IN(3), .SETTLE_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .op(op_b), .stim(stim_b), .dut_s(dut_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .bad_op(bad_b),
    .err_count(err_b), .first_fail(ff_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test for A: 0 correct AND, 1 OR gate, 2 tied high
  always_comb begin
    dut_a = 1'b0;
    case (mode_a)
      0: dut_a = &stim_a;
      1: dut_a = |stim_a;
      2: dut_a = 1'b1;
      default: dut_a = 1'b0;
    endcase
  end
  assign dut_b = ~^stim_b;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input int e, input int f, input int p, input int b, input int s, input int l);
    exp_t x;
    x.err = e; x.ff = f; x.pass = p; x.bad = b; x.stim = s; x.len = l;
    qa.push_back(x);
  endtask

  task automatic push_b(input int e, input int f, input int p, input int b, input int s, input int l);
    exp_t x;
    x.err = e; x.ff = f; x.pass = p; x.bad = b; x.stim = s; x.len = l;
    qb.push_back(x);
  endtask

  task automatic pulse_a(input logic [2:0] o);
    @(posedge clk); #1 op_a = o; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [2:0] o);
    @(posedge clk); #1 op_b = o; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int bound);
    int n;
    n = 0;
    while (!done_a && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done_a) check("timeout_a", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_done_b(input int bound);
    int n;
    n = 0;
    while (!done_b && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done_b) check("timeout_b", 0, 1);
    @(negedge clk);
  endtask

  // Monitor A: accumulate busy cycles, compare results when done rises
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      len_a = 0;
      prev_done_a = 1'b0;
    end else begin
      if (busy_a) len_a++;
      if (done_a && !prev_done_a) begin
        if (qa.size() == 0) begin
          check("a_unexpected_done", 1, 0);
        end else begin
          e = qa.pop_front();
          check("a_err_count", int'(err_a), e.err);
          check("a_first_fail", int'(ff_a), e.ff);
          check("a_pass", int'(pass_a), e.pass);
          check("a_bad_op", int'(bad_a), e.bad);
          check("a_final_stim", int'(stim_a), e.stim);
          check("a_sweep_len", len_a, e.len);
        end
        len_a = 0;
      end
      prev_done_a = done_a;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      len_b = 0;
      prev_done_b = 1'b0;
    end else begin
      if (busy_b) len_b++;
      if (done_b && !prev_done_b) begin
        if (qb.size() == 0) begin
          check("b_unexpected_done", 1, 0);
        end else begin
          e = qb.pop_front();
          check("b_err_count", int'(err_b), e.err);
          check("b_first_fail", int'(ff_b), e.ff);
          check("b_pass", int'(pass_b), e.pass);
          check("b_bad_op", int'(bad_b), e.bad);
          check("b_final_stim", int'(stim_b), e.stim);
          check("b_sweep_len", len_b, e.len);
        end
        len_b = 0;
      end
      prev_done_b = done_b;
    end
  end

  initial begin
    int n;
    total = 0; bad = 0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    op_a = 3'd0; op_b = 3'd0; mode_a = 0;
    len_a = 0; len_b = 0; prev_done_a = 1'b0; prev_done_b = 1'b0;

    @(negedge clk);
    check("rst_stim", int'(stim_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_pass", int'(pass_a), 0);
    check("rst_bad_op", int'(bad_a), 0);
    check("rst_err", int'(err_a), 0);
    check("rst_ff", int'(ff_a), 0);
    check("rst_b_busy", int'(busy_b), 0);
    #1 rst = 1'b0;

    // Correct AND gate
    mode_a = 0;
    push_a(0, 0, 1, 0, 3, 8);
    pulse_a(3'd0);
    check("a_busy_after_start", int'(busy_a), 1);
    wait_done_a(40);

    // OR gate checked as AND, with a mid-sweep start and op change that must be ignored
    mode_a = 1;
    push_a(2, 1, 0, 0, 3, 8);
    pulse_a(3'd0);
    repeat (3) @(posedge clk);
    #1 op_a = 3'd2; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done_a(40);

    // Reset in the middle of an AND sweep
    mode_a = 0;
    pulse_a(3'd0);
    n = 0;
    while (stim_a != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_vec2", int'(stim_a), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_stim", int'(stim_a), 0);
    check("arst_busy", int'(busy_a), 0);
    check("arst_done", int'(done_a), 0);
    check("arst_pass", int'(pass_a), 0);
    check("arst_err", int'(err_a), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    push_a(0, 0, 1, 0, 3, 8);
    pulse_a(3'd0);
    check("restart_stim", int'(stim_a), 0);
    wait_done_a(40);
    @(negedge clk);

    // Reset again so the illegal-op done produces a fresh rising edge
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    push_a(0, 0, 0, 1, 0, 0);
    pulse_a(3'd6);
    @(negedge clk);
    check("illegal_done", int'(done_a), 1);
    check("illegal_bad_op", int'(bad_a), 1);
    check("illegal_pass", int'(pass_a), 0);
    check("illegal_busy", int'(busy_a), 0);
    repeat (3) @(negedge clk);

    // DUT tied high, then a re-run that must start from cleared results
    mode_a = 2;
    push_a(3, 0, 0, 0, 3, 8);
    pulse_a(3'd0);
    wait_done_a(40);
    push_a(3, 0, 0, 0, 3, 8);
    pulse_a(3'd0);
    check("rerun_err_cleared", int'(err_a), 0);
    check("rerun_done_cleared", int'(done_a), 0);
    check("rerun_stim_zero", int'(stim_a), 0);
    wait_done_a(40);

    // N_IN=3, SETTLE=3: correct XNOR, then XOR against the XNOR gate (every vector fails)
    push_b(0, 0, 1, 0, 7, 32);
    pulse_b(3'd5);
    wait_done_b(100);
    push_b(8, 0, 0, 0, 7, 32);
    pulse_b(3'd2);
    wait_done_b(100);

    repeat (3) @(negedge clk);
    check("sb_a_leftover", qa.size(), 0);
    check("sb_b_leftover", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
